metadata_fetch_scheduler: RTL and testbench

Sequences per-note timestamp fetches from the chart metadata controller into per-lane "next note time" slots consumed by the note-lane renderers. Lanes flag consumption; the block queues a refill per consumed lane, grants one lane at a time round-robin, issues a one-cycle one-hot `metadata_request`, and captures the returned 16-bit timestamp. A returned timestamp of 0 marks the lane exhausted.

---
 rtl/metadata_fetch_scheduler_pkg.sv | 15 +
 rtl/metadata_fetch_scheduler_rr_arbiter.sv | 31 +++
 rtl/metadata_fetch_scheduler.sv | 140 ++++++++++++++
 tb/tb_metadata_fetch_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metadata_fetch_scheduler_pkg.sv
// rtl/metadata_fetch_scheduler_pkg.sv - shared constants and FSM state type for the metadata fetch scheduler
package cl_pkg;

    localparam int NUM_NOTES = 37;
    localparam int TIME_W    = 16;
    localparam logic [NUM_NOTES-1:0] LANE_MASK = 37'h0_9500_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        CAP  = 2'd3
    } state_t;

endpackage

// File: rtl/metadata_fetch_scheduler_rr_arbiter.sv
// rtl/metadata_fetch_scheduler_rr_arbiter.sv - rotate-priority encoder granting the lowest request above last
module rr_arbiter #(
    parameter int N  = 37,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW:0] w_idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        // walk offsets from farthest to nearest so the nearest hit above last wins
        for (int k = N; k >= 1; k--) begin
            w_idx = {1'b0, last} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N)) begin
                w_idx = w_idx - (IW+1)'(N);
            end
            if (req[w_idx[IW-1:0]]) begin
                gnt_idx = w_idx[IW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/metadata_fetch_scheduler.sv
// rtl/metadata_fetch_scheduler.sv - round-robin refill of per-lane next-note timestamps from the metadata source
module metadata_fetch_scheduler #(
    parameter int NUM_NOTES = cl_pkg::NUM_NOTES,
    parameter int TIME_W    = cl_pkg::TIME_W,
    parameter logic [NUM_NOTES-1:0] LANE_MASK = cl_pkg::LANE_MASK
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        song_start,
    input  logic [NUM_NOTES-1:0]        lane_consume,
    input  logic [NUM_NOTES*TIME_W-1:0] metadata_link,
    output logic [NUM_NOTES-1:0]        metadata_request,
    output logic [NUM_NOTES*TIME_W-1:0] next_time,
    output logic [NUM_NOTES-1:0]        next_valid,
    output logic [NUM_NOTES-1:0]        lane_done,
    output logic                        busy,
    output logic                        all_done,
    output logic                        consume_err
);

    localparam int IW = $clog2(NUM_NOTES);
    localparam int BW = $clog2(NUM_NOTES*TIME_W);

    cl_pkg::state_t r_state, w_state_nxt;

    logic [IW-1:0]               r_sel;
    logic [IW-1:0]               r_last;
    logic [NUM_NOTES-1:0]        r_pending;
    logic [NUM_NOTES-1:0]        r_next_valid;
    logic [NUM_NOTES-1:0]        r_lane_done;
    logic [NUM_NOTES*TIME_W-1:0] r_next_time;
    logic                        r_consume_err;
    logic                        r_all_done;
    logic                        r_started;

    logic [IW-1:0]        w_gnt_idx;
    logic                 w_gnt_any;
    logic [BW-1:0]        w_base;
    logic [TIME_W-1:0]    w_link_t;
    logic [NUM_NOTES-1:0] w_req;
    logic                 w_busy;

    rr_arbiter #(
        .N  (NUM_NOTES),
        .IW (IW)
    ) u_arb (
        .req     (r_pending),
        .last    (r_last),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_base   = BW'(r_sel) * BW'(TIME_W);
    assign w_link_t = metadata_link[w_base +: TIME_W];
    assign w_busy   = (|r_pending) || (r_state != cl_pkg::IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= cl_pkg::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            cl_pkg::IDLE: if (w_gnt_any) w_state_nxt = cl_pkg::REQ;
            cl_pkg::REQ:  w_state_nxt = cl_pkg::WAIT;
            cl_pkg::WAIT: w_state_nxt = cl_pkg::CAP;
            cl_pkg::CAP:  w_state_nxt = cl_pkg::IDLE;
            default:      w_state_nxt = cl_pkg::IDLE;
        endcase
    end

    always_comb begin
        w_req = '0;
        if (r_state == cl_pkg::REQ) begin
            w_req[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel         <= '0;
            r_last        <= IW'(NUM_NOTES-1);
            r_pending     <= '0;
            r_next_valid  <= '0;
            r_lane_done   <= '0;
            r_next_time   <= '0;
            r_consume_err <= 1'b0;
            r_all_done    <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            if (r_state == cl_pkg::IDLE && w_gnt_any) begin
                r_sel <= w_gnt_idx;
            end
            // a start while idle overrides any same-cycle consumes
            if (song_start && !w_busy) begin
                r_pending    <= LANE_MASK;
                r_next_valid <= '0;
                r_lane_done  <= '0;
                r_next_time  <= '0;
                r_started    <= 1'b1;
            end else begin
                if (r_state == cl_pkg::CAP) begin
                    r_pending[r_sel] <= 1'b0;
                    r_last           <= r_sel;
                    if (w_link_t != '0) begin
                        r_next_time[w_base +: TIME_W] <= w_link_t;
                        r_next_valid[r_sel]           <= 1'b1;
                    end else begin
                        r_lane_done[r_sel]  <= 1'b1;
                        r_next_valid[r_sel] <= 1'b0;
                    end
                end
                for (int i = 0; i < NUM_NOTES; i++) begin
                    if (lane_consume[i] && r_next_valid[i] && !r_lane_done[i]) begin
                        r_next_valid[i] <= 1'b0;
                        r_pending[i]    <= 1'b1;
                    end
                end
                if (|(lane_consume & ~r_next_valid)) begin
                    r_consume_err <= 1'b1;
                end
            end
            r_all_done <= ((LANE_MASK != '0) || r_started) &&
                          ((r_lane_done & LANE_MASK) == LANE_MASK);
        end
    end

    assign metadata_request = w_req;
    assign next_time        = r_next_time;
    assign next_valid       = r_next_valid;
    assign lane_done        = r_lane_done;
    assign busy             = w_busy;
    assign all_done         = r_all_done;
    assign consume_err      = r_consume_err;

endmodule

// File: tb/tb_metadata_fetch_scheduler.sv
// tb/tb_metadata_fetch_scheduler.sv - scoreboard bench for metadata_fetch_scheduler
module tb_metadata_fetch_scheduler;

    localparam int N  = 37;
    localparam int TW = 16;
    localparam logic [N-1:0] MASK = 37'h0_9500_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            song_start = 1'b0;
    logic [N-1:0]    lane_consume = '0;
    logic [N*TW-1:0] metadata_link = '0;
    logic [N-1:0]    metadata_request;
    logic [N*TW-1:0] next_time;
    logic [N-1:0]    next_valid;
    logic [N-1:0]    lane_done;
    logic            busy;
    logic            all_done;
    logic            consume_err;

    metadata_fetch_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .song_start       (song_start),
        .lane_consume     (lane_consume),
        .metadata_link    (metadata_link),
        .metadata_request (metadata_request),
        .next_time        (next_time),
        .next_valid       (next_valid),
        .lane_done        (lane_done),
        .busy             (busy),
        .all_done         (all_done),
        .consume_err      (consume_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          lane;
        logic [15:0] t;
    } exp_t;

    exp_t        exp_q[$];
    int          req_cyc_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          req_count = 0;
    int          chk_lane = 0;
    int          chk_cnt = 0;
    logic [15:0] chk_t = '0;

    function automatic logic [N-1:0] lb(input int i);
        logic [N-1:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] nt(input int i);
        return next_time[i*TW +: TW];
    endfunction

    task automatic push_exp(input int lane, input logic [15:0] t);
        exp_t e;
        e.lane = lane;
        e.t = t;
        exp_q.push_back(e);
    endtask

    // models the metadata source and scores each request and its capture
    task automatic monitor();
        exp_t e;
        int   lane;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_cnt = 0;
                exp_q.delete();
                continue;
            end
            if (chk_cnt > 0) begin
                chk_cnt--;
                if (chk_cnt == 0) begin
                    n_total++;
                    if (chk_t != 0) begin
                        if (next_valid[chk_lane] !== 1'b1 || nt(chk_lane) !== chk_t)
                            $display("FAIL capture lane %0d: valid=%b time=%0d, expected valid=1 time=%0d",
                                     chk_lane, next_valid[chk_lane], nt(chk_lane), chk_t);
                        else n_pass++;
                    end else begin
                        if (lane_done[chk_lane] !== 1'b1 || next_valid[chk_lane] !== 1'b0)
                            $display("FAIL exhaust lane %0d: done=%b valid=%b, expected done=1 valid=0",
                                     chk_lane, lane_done[chk_lane], next_valid[chk_lane]);
                        else n_pass++;
                    end
                end
            end
            if (metadata_request != '0) begin
                req_count++;
                req_cyc_q.push_back(cyc);
                n_total++;
                if (!$onehot(metadata_request))
                    $display("FAIL request_onehot: got %h, expected one-hot", metadata_request);
                else n_pass++;
                lane = 0;
                for (int i = 0; i < N; i++) if (metadata_request[i]) lane = i;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_request: lane %0d, expected none", lane);
                end else begin
                    e = exp_q.pop_front();
                    if (lane !== e.lane)
                        $display("FAIL request_order: got lane %0d, expected lane %0d", lane, e.lane);
                    else n_pass++;
                    metadata_link[lane*TW +: TW] = e.t;
                    chk_lane = lane;
                    chk_t = e.t;
                    chk_cnt = 3;
                end
            end
        end
    endtask

    task automatic pulse_consume(input logic [N-1:0] m);
        @(posedge clk); #1 lane_consume = m;
        @(posedge clk); #1 lane_consume = '0;
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1 song_start = 1'b1; s = cyc;
        @(posedge clk); #1 song_start = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, k);
        else n_pass++;
        c = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({metadata_request, next_valid, lane_done, busy, all_done, consume_err} !== '0)
            $display("FAIL reset_outputs: req=%h valid=%h done=%h busy=%b all=%b err=%b, expected all 0",
                     metadata_request, next_valid, lane_done, busy, all_done, consume_err);
        else n_pass++;
        n_total++;
        if (next_time !== '0) $display("FAIL reset_next_time: got %h, expected 0", next_time);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (req_count !== 0 || busy !== 1'b0)
            $display("FAIL idle_after_reset: requests=%0d busy=%b, expected 0 and 0", req_count, busy);
        else n_pass++;
    endtask

    task automatic test_song_start();
        int s, c;
        logic [15:0] tv[4] = '{16'd400, 16'd300, 16'd200, 16'd1500};
        int          ln[4] = '{24, 26, 28, 31};
        req_cyc_q.delete();
        for (int i = 0; i < 4; i++) push_exp(ln[i], tv[i]);
        pulse_start(s);
        repeat (4) @(posedge clk);
        #1 song_start = 1'b1;
        @(posedge clk); #1 song_start = 1'b0;
        wait_idle(c);
        n_total++;
        if (req_cyc_q.size() !== 4) $display("FAIL start_req_count: got %0d, expected 4", req_cyc_q.size());
        else n_pass++;
        if (req_cyc_q.size() == 4) begin
            n_total++;
            if (req_cyc_q[0] !== s + 2)
                $display("FAIL start_latency: first request cycle %0d, expected %0d", req_cyc_q[0], s + 2);
            else n_pass++;
            for (int i = 1; i < 4; i++) begin
                n_total++;
                if (req_cyc_q[i] - req_cyc_q[i-1] !== 4)
                    $display("FAIL request_spacing %0d: gap %0d, expected 4", i, req_cyc_q[i] - req_cyc_q[i-1]);
                else n_pass++;
            end
        end
        n_total++;
        if (next_valid !== MASK) $display("FAIL start_valid: got %h, expected %h", next_valid, MASK);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (nt(ln[i]) !== tv[i]) $display("FAIL start_time lane %0d: got %0d, expected %0d", ln[i], nt(ln[i]), tv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_refill();
        int c;
        logic [15:0] tv[3] = '{16'd2000, 16'd3000, 16'd0};
        for (int i = 0; i < 3; i++) begin
            push_exp(24, tv[i]);
            pulse_consume(lb(24));
            wait_idle(c);
            repeat (2) @(negedge clk);
            n_total++;
            if (tv[i] != 0) begin
                if (next_valid[24] !== 1'b1 || nt(24) !== tv[i])
                    $display("FAIL refill %0d: valid=%b time=%0d, expected valid=1 time=%0d", i, next_valid[24], nt(24), tv[i]);
                else n_pass++;
            end else begin
                if (lane_done[24] !== 1'b1 || next_valid[24] !== 1'b0)
                    $display("FAIL refill_exhaust: done=%b valid=%b, expected done=1 valid=0", lane_done[24], next_valid[24]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        req_cyc_q.delete();
        push_exp(26, 16'd310);
        push_exp(28, 16'd210);
        push_exp(31, 16'd1510);
        pulse_consume(lb(31) | lb(26) | lb(28));
        wait_idle(c);
        n_total++;
        if (req_cyc_q.size() !== 3) $display("FAIL multi_req_count: got %0d, expected 3", req_cyc_q.size());
        else n_pass++;
        if (req_cyc_q.size() == 3) begin
            n_total++;
            if (c !== req_cyc_q[2] + 3)
                $display("FAIL busy_drop: busy low at cycle %0d, expected %0d", c, req_cyc_q[2] + 3);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
        n_total++;
        if (nt(31) !== 16'd1510) $display("FAIL multi_time31: got %0d, expected 1510", nt(31));
        else n_pass++;
    endtask

    task automatic test_double_consume();
        int c, n0;
        n_total++;
        if (consume_err !== 1'b0) $display("FAIL err_before: got %b, expected 0", consume_err);
        else n_pass++;
        n0 = req_count;
        push_exp(26, 16'd320);
        @(posedge clk); #1 lane_consume = lb(26);
        @(posedge clk); #1 lane_consume = lb(26);
        @(posedge clk); #1 lane_consume = '0;
        wait_idle(c);
        repeat (2) @(negedge clk);
        n_total++;
        if (consume_err !== 1'b1) $display("FAIL err_after: got %b, expected 1", consume_err);
        else n_pass++;
        n_total++;
        if (req_count - n0 !== 1) $display("FAIL double_req_count: got %0d, expected 1", req_count - n0);
        else n_pass++;
        n_total++;
        if (nt(26) !== 16'd320) $display("FAIL double_time: got %0d, expected 320", nt(26));
        else n_pass++;
    endtask

    task automatic test_exhaust_restart();
        int c, s, k;
        push_exp(28, 16'd0);
        push_exp(31, 16'd0);
        push_exp(26, 16'd0);
        pulse_consume(lb(26) | lb(28) | lb(31));
        k = 0;
        while (lane_done[26] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (all_done !== 1'b0) $display("FAIL all_done_early: got %b, expected 0", all_done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (all_done !== 1'b1 || lane_done !== MASK)
            $display("FAIL all_done: all=%b done=%h, expected 1 and %h", all_done, lane_done, MASK);
        else n_pass++;
        wait_idle(c);
        req_cyc_q.delete();
        push_exp(28, 16'd500);
        push_exp(31, 16'd510);
        push_exp(24, 16'd520);
        push_exp(26, 16'd530);
        pulse_start(s);
        @(negedge clk);
        n_total++;
        if (next_valid !== '0 || lane_done !== '0 || next_time !== '0 || busy !== 1'b1)
            $display("FAIL restart_clear: valid=%h done=%h busy=%b, expected 0 0 1", next_valid, lane_done, busy);
        else n_pass++;
        wait_idle(c);
        repeat (2) @(negedge clk);
        n_total++;
        if (next_valid !== MASK || req_cyc_q.size() !== 4)
            $display("FAIL restart_refetch: valid=%h requests=%0d, expected %h and 4", next_valid, req_cyc_q.size(), MASK);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n0, k;
        n0 = req_count;
        push_exp(24, 16'd999);
        pulse_consume(lb(24));
        k = 0;
        while (req_count == n0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({metadata_request, next_valid, lane_done, busy, all_done, consume_err} !== '0 || next_time !== '0)
            $display("FAIL mid_reset: req=%h valid=%h done=%h busy=%b all=%b err=%b, expected all 0",
                     metadata_request, next_valid, lane_done, busy, all_done, consume_err);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        n0 = req_count;
        repeat (20) @(negedge clk);
        n_total++;
        if (req_count !== n0 || busy !== 1'b0)
            $display("FAIL post_reset_quiet: new requests=%0d busy=%b, expected 0 and 0", req_count - n0, busy);
        else n_pass++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_song_start();
        test_refill();
        test_back_to_back();
        test_double_consume();
        test_exhaust_restart();
        test_reset_mid();
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL leftover_expected: %0d entries, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
